// File: rtl/vga_frame_monitor_if.sv
// vga_frame_monitor_if: VGA output bus as seen at the off-chip pins, plus the
// pixel-clock enable that qualifies every sample. The output stage drives it
// (master); the frame monitor only observes it (slave).
interface vga_frame_monitor_if;
  logic       pix_en;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;

  modport master (
    output pix_en, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
  );

  modport slave (
    input  pix_en, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
  );
endinterface

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: passive sink for the VGA output. Recovers line and frame
// structure from the sync edges, measures active width, active height and
// line length against the expected timing, and raises a sticky timing error.
// Define VGA_MON_SIGNATURE_EN to build the per-frame pixel signature
// accumulator; without it, signature is tied to zero.
module vga_frame_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480
) (
  input  logic               clk,
  input  logic               rst,
  vga_frame_monitor_if.slave vga,
  input  logic               err_clr,
  output logic               frame_done,
  output logic [15:0]        frame_count,
  output logic [11:0]        h_active_meas,
  output logic [11:0]        v_active_meas,
  output logic [23:0]        signature,
  output logic               timing_err
);

  typedef enum logic {WAIT_VS, IN_FRAME} state_t;

  localparam logic [11:0] CNT_MAX    = 12'hFFF;
  localparam logic [11:0] H_ACTIVE_C = 12'(H_ACTIVE);
  localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL);
  localparam logic [11:0] V_ACTIVE_C = 12'(V_ACTIVE);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CNT_MAX) ? v : v + 12'd1;
  endfunction

  state_t      state;
  logic        hs_q, vs_q;
  logic        first_line;     // no full line seen yet since the frame start
  logic [11:0] pix_cnt;        // active pixels in the current line
  logic [11:0] line_cnt;       // completed lines that held active pixels
  logic [11:0] line_len;       // samples since the last HS edge
  logic [11:0] last_h;         // pixel count of the last completed active line

  logic        hs_edge, vs_edge, active, open_line, err_set;
  logic [11:0] v_fold, h_fold;
  logic [23:0] pixel;

  assign hs_edge   = vga.pix_en & hs_q & ~vga.VGA_HS;
  assign vs_edge   = vga.pix_en & vs_q & ~vga.VGA_VS;
  assign active    = vga.pix_en & vga.VGA_BLANK_N;
  assign pixel     = {vga.VGA_R, vga.VGA_G, vga.VGA_B};
  assign open_line = (pix_cnt != 12'd0);
  // A line still open at the frame end is folded into the results.
  assign v_fold    = open_line ? sat_inc(line_cnt) : line_cnt;
  assign h_fold    = open_line ? pix_cnt : last_h;

  // Error detection for the sample being taken this cycle.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it holding its old value and infer a latch.
  always_comb begin
    err_set = 1'b0;
    if (vs_edge && active)
      err_set = 1'b1;
    if (state == IN_FRAME && vga.pix_en) begin
      if (vs_edge) begin
        if (open_line && (pix_cnt != H_ACTIVE_C || line_cnt == CNT_MAX))
          err_set = 1'b1;
        if (v_fold != V_ACTIVE_C)
          err_set = 1'b1;
      end else if (hs_edge) begin
        if (open_line && (pix_cnt != H_ACTIVE_C || line_cnt == CNT_MAX))
          err_set = 1'b1;
        if (!first_line && line_len != H_TOTAL_C)
          err_set = 1'b1;
      end else begin
        if (line_len == CNT_MAX)
          err_set = 1'b1;
        if (active && pix_cnt == CNT_MAX)
          err_set = 1'b1;
      end
    end
  end

  // Frame/line state machine, measurement counters and registered results.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_VS;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      first_line    <= 1'b0;
      pix_cnt       <= 12'd0;
      line_cnt      <= 12'd0;
      line_len      <= 12'd0;
      last_h        <= 12'd0;
      frame_done    <= 1'b0;
      frame_count   <= 16'd0;
      h_active_meas <= 12'd0;
      v_active_meas <= 12'd0;
      timing_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (err_set)
        timing_err <= 1'b1;
      else if (err_clr)
        timing_err <= 1'b0;

      if (vga.pix_en) begin
        hs_q <= vga.VGA_HS;
        vs_q <= vga.VGA_VS;
      end

      if (vs_edge) begin
        if (state == IN_FRAME) begin
          frame_done    <= 1'b1;
          frame_count   <= frame_count + 16'd1;
          h_active_meas <= h_fold;
          v_active_meas <= v_fold;
        end
        state      <= IN_FRAME;
        // A pixel on the VS edge sample is the first pixel of the new frame.
        pix_cnt    <= active ? 12'd1 : 12'd0;
        line_cnt   <= 12'd0;
        last_h     <= 12'd0;
        line_len   <= 12'd1;
        first_line <= 1'b1;
      end else if (state == IN_FRAME && vga.pix_en) begin
        if (hs_edge) begin
          if (open_line) begin
            line_cnt <= sat_inc(line_cnt);
            last_h   <= pix_cnt;
          end
          pix_cnt    <= active ? 12'd1 : 12'd0;
          line_len   <= 12'd1;
          first_line <= 1'b0;
        end else begin
          line_len <= sat_inc(line_len);
          if (active)
            pix_cnt <= sat_inc(pix_cnt);
        end
      end
    end
  end

`ifdef VGA_MON_SIGNATURE_EN
  logic [23:0] sig;

  // Rotate-and-xor signature over the active pixels of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig       <= 24'h0;
      signature <= 24'h0;
    end else if (vs_edge) begin
      if (state == IN_FRAME)
        signature <= sig;
      sig <= active ? pixel : 24'h0;
    end else if (state == IN_FRAME && active) begin
      sig <= {sig[22:0], sig[23]} ^ pixel;
    end
  end
`else
  logic unused_pixel;

  assign unused_pixel = ^pixel;
  assign signature    = 24'h0;
`endif

endmodule
